eclass_controller: RTL and testbench

ECLASS_CONTROLLER -- requirements
Module: eclass_controller

---
 rtl/eclass_controller.sv | 190 +++++++++++++++++++
 tb/tb_eclass_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eclass_controller.sv
// eclass_controller: Moore FSM sequencing the equivalence-class datapath
// (init, check, fetch, decide, write eclass/fmap memory, step i/j, done).
// Latency: start in IDLE -> INIT next cycle -> CHECK the cycle after.
// Backpressure: none; start is ignored outside IDLE, done is a 1-cycle pulse.
//
// Ports:
//   clk, reset (synchronous, active-high), start, notReturn, cont1..cont3 : inputs
//   fmapAddrSel[3:0], jSel[3:0], iSel[2:0], eclassSel[1:0], fmapDataSel[1:0] : mux selects
//   loadi, loadj, loadtmp, loadec_tmp : register loads
//   eclassMemWrite, fmapMemWrite : memory write enables
//   busy, done, err : status
// Optional feature macro: CTRL_WATCHDOG_EN adds a 16-bit iteration watchdog
// that ends a run with err=1 once MAX_ITER CHECK entries have occurred.

module eclass_controller #(
    parameter int MAX_ITER = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       notReturn,
    input  logic       cont1,
    input  logic       cont2,
    input  logic       cont3,
    output logic [3:0] fmapAddrSel,
    output logic [3:0] jSel,
    output logic [2:0] iSel,
    output logic [1:0] eclassSel,
    output logic [1:0] fmapDataSel,
    output logic       loadi,
    output logic       loadj,
    output logic       loadtmp,
    output logic       loadec_tmp,
    output logic       eclassMemWrite,
    output logic       fmapMemWrite,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // The watchdog counter is 16 bits wide, so the limit must fit in it.
    if (MAX_ITER < 1 || MAX_ITER > 65535) begin : g_bad_max_iter
        $error("eclass_controller: MAX_ITER must be in 1..65535");
    end

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        CHECK,
        FETCH,
        DECIDE,
        WR_EC,
        WR_FMAP,
        STEP_I,
        STEP_J,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   wd_hit;

`ifdef CTRL_WATCHDOG_EN
    localparam logic [15:0] ITER_LIMIT = 16'(MAX_ITER);

    logic [15:0] iter_cnt;
    logic        err_q;

    // The limit is compared before this CHECK's increment, so the run ends
    // on the CHECK entry after MAX_ITER entries have completed.
    assign wd_hit = (state == CHECK) && (iter_cnt == ITER_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            iter_cnt <= '0;
            err_q    <= 1'b0;
        end else if (state == INIT) begin
            iter_cnt <= '0;
            err_q    <= 1'b0;
        end else if (state == CHECK) begin
            if (wd_hit) begin
                err_q <= 1'b1;
            end else begin
                iter_cnt <= iter_cnt + 16'd1;
            end
        end
    end
`else
    logic err_q;

    assign wd_hit = 1'b0;
    assign err_q  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = INIT;
            INIT:    state_nxt = CHECK;
            CHECK: begin
                if (wd_hit || !notReturn) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = FETCH;
                end
            end
            FETCH:   state_nxt = DECIDE;
            DECIDE: begin
                if (cont1) begin
                    state_nxt = WR_EC;
                end else if (cont2) begin
                    state_nxt = WR_FMAP;
                end else if (cont3) begin
                    state_nxt = STEP_I;
                end else begin
                    state_nxt = STEP_J;
                end
            end
            WR_EC:   state_nxt = STEP_J;
            WR_FMAP: state_nxt = STEP_J;
            STEP_I:  state_nxt = CHECK;
            STEP_J:  state_nxt = CHECK;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs depend on the current state only (err_q is stable through DONE).
    always_comb begin
        fmapAddrSel    = 4'd0;
        jSel           = 4'd0;
        iSel           = 3'd0;
        eclassSel      = 2'd0;
        fmapDataSel    = 2'd0;
        loadi          = 1'b0;
        loadj          = 1'b0;
        loadtmp        = 1'b0;
        loadec_tmp     = 1'b0;
        eclassMemWrite = 1'b0;
        fmapMemWrite   = 1'b0;
        busy           = (state != IDLE);
        done           = 1'b0;
        err            = 1'b0;
        case (state)
            INIT: begin
                iSel  = 3'd1;
                jSel  = 4'd1;
                loadi = 1'b1;
                loadj = 1'b1;
            end
            FETCH: begin
                fmapAddrSel = 4'd1;
                eclassSel   = 2'd1;
                loadtmp     = 1'b1;
                loadec_tmp  = 1'b1;
            end
            WR_EC: begin
                eclassSel      = 2'd2;
                eclassMemWrite = 1'b1;
            end
            WR_FMAP: begin
                fmapAddrSel  = 4'd2;
                fmapDataSel  = 2'd1;
                fmapMemWrite = 1'b1;
            end
            STEP_I: begin
                iSel  = 3'd2;
                loadi = 1'b1;
            end
            STEP_J: begin
                jSel  = 4'd2;
                loadj = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_eclass_controller.sv
// tb_eclass_controller: directed stimulus for eclass_controller with a
// phase-level reference model compared against all outputs every cycle.
// Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.

module tb_eclass_controller;

    localparam int MAX_ITER = 4;

    logic       clk;
    logic       reset;
    logic       start;
    logic       notReturn;
    logic       cont1;
    logic       cont2;
    logic       cont3;
    logic [3:0] fmapAddrSel;
    logic [3:0] jSel;
    logic [2:0] iSel;
    logic [1:0] eclassSel;
    logic [1:0] fmapDataSel;
    logic       loadi;
    logic       loadj;
    logic       loadtmp;
    logic       loadec_tmp;
    logic       eclassMemWrite;
    logic       fmapMemWrite;
    logic       busy;
    logic       done;
    logic       err;

    eclass_controller #(.MAX_ITER(MAX_ITER)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .notReturn     (notReturn),
        .cont1         (cont1),
        .cont2         (cont2),
        .cont3         (cont3),
        .fmapAddrSel   (fmapAddrSel),
        .jSel          (jSel),
        .iSel          (iSel),
        .eclassSel     (eclassSel),
        .fmapDataSel   (fmapDataSel),
        .loadi         (loadi),
        .loadj         (loadj),
        .loadtmp       (loadtmp),
        .loadec_tmp    (loadec_tmp),
        .eclassMemWrite(eclassMemWrite),
        .fmapMemWrite  (fmapMemWrite),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Flattened output word, same field order for DUT and model.
    logic [23:0] dut_vec;
    assign dut_vec = {fmapAddrSel, jSel, iSel, eclassSel, fmapDataSel,
                      loadi, loadj, loadtmp, loadec_tmp,
                      eclassMemWrite, fmapMemWrite, busy, done, err};

    // ---------------- reference model (phase of the algorithm) ----------------
    localparam int P_IDLE = 0, P_INIT = 1, P_CHECK = 2, P_FETCH = 3, P_DECIDE = 4;
    localparam int P_WREC = 5, P_WRFM = 6, P_STI = 7, P_STJ = 8, P_DONE = 9;

    int m_ph   = P_IDLE;
    int m_iter = 0;   // CHECK entries completed in this run
    bit m_err  = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_ph = P_IDLE; m_iter = 0; m_err = 1'b0;
        end else begin
            case (m_ph)
                P_IDLE:   if (start) m_ph = P_INIT;
                P_INIT:   begin m_iter = 0; m_err = 1'b0; m_ph = P_CHECK; end
                P_CHECK: begin
`ifdef CTRL_WATCHDOG_EN
                    if (m_iter == MAX_ITER) begin
                        m_err = 1'b1; m_ph = P_DONE;
                    end else
`endif
                    begin
                        m_iter++;
                        m_ph = notReturn ? P_FETCH : P_DONE;
                    end
                end
                P_FETCH:  m_ph = P_DECIDE;
                P_DECIDE: m_ph = cont1 ? P_WREC : cont2 ? P_WRFM : cont3 ? P_STI : P_STJ;
                P_WREC, P_WRFM: m_ph = P_STJ;
                P_STI, P_STJ:   m_ph = P_CHECK;
                default:  m_ph = P_IDLE;
            endcase
        end
    end

    function automatic logic [23:0] exp_out(input int ph, input bit e);
        logic [3:0] fa, js; logic [2:0] is; logic [1:0] es, fd;
        logic li, lj, lt, le, ew, fw, dn, er;
        fa = 0; js = 0; is = 0; es = 0; fd = 0;
        li = 0; lj = 0; lt = 0; le = 0; ew = 0; fw = 0; dn = 0; er = 0;
        case (ph)
            P_INIT:  begin is = 1; js = 1; li = 1; lj = 1; end
            P_FETCH: begin fa = 1; es = 1; lt = 1; le = 1; end
            P_WREC:  begin es = 2; ew = 1; end
            P_WRFM:  begin fa = 2; fd = 1; fw = 1; end
            P_STI:   begin is = 2; li = 1; end
            P_STJ:   begin js = 2; lj = 1; end
            P_DONE:  begin dn = 1; er = e; end
            default: ;
        endcase
        return {fa, js, is, es, fd, li, lj, lt, le, ew, fw, (ph != P_IDLE), dn, er};
    endfunction

    // ---------------- compare process + event counters ----------------
    bit chk_en = 1'b0;
    int n_done = 0, n_stepj = 0, n_loadi_x = 0, n_ecw = 0, n_fmw = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("outputs_vs_model", int'(dut_vec), int'(exp_out(m_ph, m_err)));
            chk("memwrite_exclusive", int'(eclassMemWrite & fmapMemWrite), 0);
        end
        if (done) n_done++;
        if (loadj && jSel == 4'd2) n_stepj++;
        if (loadi && iSel != 3'd1) n_loadi_x++;
        if (eclassMemWrite) n_ecw++;
        if (fmapMemWrite) n_fmw++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();          // start sampled at this edge; now in INIT
        start = 1'b0;
    endtask

    // Returns ticks taken from the current cycle until done is seen.
    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            tick();
            cyc++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    int cyc, b_done, b_stepj, b_lix, b_ecw, b_fmw;

    task automatic snap();
        b_done = n_done; b_stepj = n_stepj; b_lix = n_loadi_x; b_ecw = n_ecw; b_fmw = n_fmw;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; notReturn = 1'b0;
        cont1 = 1'b0; cont2 = 1'b0; cont3 = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_outputs", int'(dut_vec), 0);
        reset = 1'b0;
        tick();

        // A: immediate return -> INIT, CHECK, DONE
        snap();
        start_run();
        chk("A_init_loadi", int'(loadi), 1);
        wait_done(20, cyc);
        chk("A_done_cycle_after_start_edge", cyc + 1, 3);
        chk("A_err", int'(err), 0);
        tick();
        chk("A_memwrites", (n_ecw - b_ecw) + (n_fmw - b_fmw), 0);
        chk("A_idle_busy", int'(busy), 0);

        // B: one loop via WR_EC
        notReturn = 1'b1; cont1 = 1'b1;
        start_run();
        tick(); tick(); tick(); tick();            // CHECK, FETCH, DECIDE, WR_EC
        chk("B_wrec_write", int'(eclassMemWrite), 1);
        chk("B_wrec_sel", int'(eclassSel), 2);
        tick();                                    // STEP_J
        chk("B_stepj_jsel", int'(jSel), 2);
        chk("B_stepj_loadj", int'(loadj), 1);
        notReturn = 1'b0; cont1 = 1'b0;
        tick(); tick();                            // CHECK, DONE
        chk("B_done", int'(done), 1);
        tick();

        // C: cont2 beats cont3
        snap();
        notReturn = 1'b1; cont2 = 1'b1; cont3 = 1'b1;
        start_run();
        tick(); tick(); tick(); tick();            // CHECK, FETCH, DECIDE, WR_FMAP
        chk("C_wrfm_fields", {fmapMemWrite, fmapDataSel, fmapAddrSel}, {1'b1, 2'd1, 4'd2});
        notReturn = 1'b0; cont2 = 1'b0; cont3 = 1'b0;
        tick();                                    // STEP_J, not STEP_I
        chk("C_after_wrfm_jsel", int'(jSel), 2);
        wait_done(20, cyc);
        tick();
        chk("C_stepi_never", n_loadi_x - b_lix, 0);

        // D: three plain STEP_J loops
        snap();
        notReturn = 1'b1;
        start_run();
        repeat (12) tick();                        // third STEP_J reached
        notReturn = 1'b0;
        wait_done(20, cyc);
        tick();
        chk("D_loadj_step_pulses", n_stepj - b_stepj, 3);
        chk("D_loadi_outside_init", n_loadi_x - b_lix, 0);

        // E: reset during WR_FMAP aborts the run
        snap();
        notReturn = 1'b1; cont2 = 1'b1;
        start_run();
        tick(); tick(); tick(); tick();            // WR_FMAP
        chk("E_in_wrfm", int'(fmapMemWrite), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0; cont2 = 1'b0; notReturn = 1'b0;
        chk("E_outputs_after_reset", int'(dut_vec), 0);
        repeat (5) tick();
        chk("E_no_done", n_done - b_done, 0);
        chk("E_single_fmap_write", n_fmw - b_fmw, 1);

        // G: start held through DONE relaunches on the following IDLE cycle
        start = 1'b1;
        tick(); tick(); tick();                    // INIT, CHECK, DONE
        chk("G_done", int'(done), 1);
        tick();                                    // IDLE, start still high
        tick();
        chk("G_relaunch_init", int'(loadi & loadj), 1);
        start = 1'b0;
        wait_done(20, cyc);
        tick();

        // F: watchdog
        snap();
        notReturn = 1'b1;
        start_run();
`ifdef CTRL_WATCHDOG_EN
        wait_done(60, cyc);
        chk("F_wd_done_cycle", cyc + 1, 19);
        chk("F_wd_err", int'(err), 1);
        tick();
        chk("F_err_cleared_in_idle", int'(err), 0);
        notReturn = 1'b0;
`else
        repeat (60) tick();
        chk("F_run_continues_busy", int'(busy), 1);
        chk("F_run_continues_no_done", n_done - b_done, 0);
        notReturn = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
`endif
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
